// File: rtl/multi_edge_detector_if.sv
// Bundle between the input conditioner and its user.
// The master drives the raw inputs and controls. The slave returns the levels, edges, flags and counts.
interface multi_edge_detector_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
);
    logic [CH-1:0]       sample;
    logic [2*CH-1:0]     mode;
    logic [CH-1:0]       flag_clr;
    logic [CH-1:0]       cnt_clr;
    logic [CH-1:0]       level;
    logic [CH-1:0]       edge_out;
    logic                any_edge;
    logic [CH-1:0]       flag;
    logic [CH*CNT_W-1:0] count;

    modport master (
        output sample, mode, flag_clr, cnt_clr,
        input  level, edge_out, any_edge, flag, count
    );

    modport slave (
        input  sample, mode, flag_clr, cnt_clr,
        output level, edge_out, any_edge, flag, count
    );
endinterface

// File: rtl/multi_edge_detector.sv
// multi_edge_detector: N-channel synchroniser, optional debounce filter and edge detector.
// Each channel also has a sticky event flag and a saturating event counter.
// Ports: clk, rst (sync, active-high), bus (multi_edge_detector_if.slave):
//   sample/mode/flag_clr/cnt_clr in; level/edge_out/any_edge/flag/count out.
// Build option: define EDGE_DEBOUNCE_EN to enable the DB_CYCLES debounce filter.
//   Without it, level follows the last synchroniser stage every cycle.
module multi_edge_detector #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int CNT_W       = 8
) (
    input logic                 clk,
    input logic                 rst,
    multi_edge_detector_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (CH < 1 || SYNC_STAGES < 2 || DB_CYCLES < 1 || CNT_W < 1) begin : g_bad_cfg
        $error("multi_edge_detector: illegal parameter set");
    end

    logic [CH-1:0]    sync_q [SYNC_STAGES];
    logic [CH-1:0]    sync_d [SYNC_STAGES];
    logic [CH-1:0]    s;
    logic [CH-1:0]    level_q, level_d;
    logic [CH-1:0]    edge_q, edge_d;
    logic [CH-1:0]    flag_q, flag_d;
    logic [CNT_W-1:0] cnt_q [CH];
    logic [CNT_W-1:0] cnt_d [CH];

    always_comb begin
        sync_d[0] = bus.sample;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    logic [DBW-1:0] db_q [CH];
    logic [DBW-1:0] db_d [CH];

    // A differing input must persist DB_CYCLES consecutive cycles before
    // it is accepted. Any return to the current level restarts the count.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < CH; i++) begin
            db_d[i] = '0;
            if (s[i] != level_q[i]) begin
                if (db_q[i] == DB_LAST) begin
                    level_d[i] = s[i];
                end else begin
                    db_d[i] = db_q[i] + DBW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                db_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
        end
    end
`else
    assign level_d = s;
`endif

    // The edge is qualified against the mode seen at the same edge that
    // updates level. As a result, edge_out and level change together.
    always_comb begin
        edge_d = '0;
        for (int i = 0; i < CH; i++) begin
            edge_d[i] = (level_d[i] & ~level_q[i] & bus.mode[2*i])
                      | (~level_d[i] & level_q[i] & bus.mode[2*i+1]);
        end
    end

    // Flag and counter react to the registered pulse. A clear issued
    // while edge_out is high therefore loses to that event.
    always_comb begin
        flag_d = edge_q | (flag_q & ~bus.flag_clr);
        for (int i = 0; i < CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.cnt_clr[i]) begin
                cnt_d[i] = edge_q[i] ? CNT_W'(1) : '0;
            end else if (edge_q[i] && cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= '0;
            end
            level_q <= '0;
            edge_q  <= '0;
            flag_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            edge_q  <= edge_d;
            flag_q  <= flag_d;
        end
    end

    assign bus.level    = level_q;
    assign bus.edge_out = edge_q;
    assign bus.any_edge = |edge_q;
    assign bus.flag     = flag_q;

    for (genvar i = 0; i < CH; i++) begin : g_pack
        assign bus.count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector with an 8-bit counter instance and a 2-bit counter instance.
// Inputs are driven and outputs are checked on the falling clock edge.
module tb_multi_edge_detector;
`ifdef EDGE_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    multi_edge_detector_if #(.CH(4), .CNT_W(8)) b ();
    multi_edge_detector_if #(.CH(1), .CNT_W(2)) bs ();

    multi_edge_detector #(
        .CH(4), .SYNC_STAGES(2), .DB_CYCLES(4), .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );

    multi_edge_detector #(
        .CH(1), .SYNC_STAGES(2), .DB_CYCLES(4), .CNT_W(2)
    ) dut_sat (
        .clk(clk),
        .rst(rst),
        .bus(bs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        b.sample    = '0;
        b.mode      = 8'b11_11_11_01;
        b.flag_clr  = '0;
        b.cnt_clr   = '0;
        bs.sample   = '0;
        bs.mode     = 2'b11;
        bs.flag_clr = '0;
        bs.cnt_clr  = '0;
        tick(3);
        rst = 1'b0;

        chk("rst_level", 32'(b.level), 32'h0);
        chk("rst_edge", 32'(b.edge_out), 32'h0);
        chk("rst_any", 32'(b.any_edge), 32'h0);
        chk("rst_flag", 32'(b.flag), 32'h0);
        chk("rst_count", b.count, 32'h0);

        // ch0 rise-only: the pulse appears LAT cycles after the input change.
        b.sample[0] = 1'b1;
        tick(LAT - 1);
        chk("t1_early", 32'(b.edge_out), 32'h0);
        tick(1);
        chk("t1_edge", 32'(b.edge_out), 32'h1);
        chk("t1_any", 32'(b.any_edge), 32'h1);
        chk("t1_level", 32'(b.level), 32'h1);
        tick(1);
        chk("t1_pulse1", 32'(b.edge_out), 32'h0);
        chk("t1_flag", 32'(b.flag), 32'h1);
        chk("t1_cnt", 32'(b.count[7:0]), 32'h1);
        b.sample[0] = 1'b0;
        tick(LAT);
        chk("t1_fall_lvl", 32'(b.level[0]), 32'h0);
        chk("t1_fall_edge", 32'(b.edge_out), 32'h0);
        tick(2);
        chk("t1_fall_cnt", 32'(b.count[7:0]), 32'h1);

`ifdef EDGE_DEBOUNCE_EN
        // ch1: a 3-cycle pulse is filtered out, and a held level is accepted.
        b.sample[1] = 1'b1;
        tick(3);
        b.sample[1] = 1'b0;
        tick(10);
        chk("t2_short_lvl", 32'(b.level[1]), 32'h0);
        chk("t2_short_cnt", 32'(b.count[15:8]), 32'h0);
        b.sample[1] = 1'b1;
        tick(LAT);
        chk("t2_edge", 32'(b.edge_out), 32'h2);
        tick(1);
        chk("t2_pulse1", 32'(b.edge_out), 32'h0);
        chk("t2_cnt", 32'(b.count[15:8]), 32'h1);
`else
        // ch1: without the filter, a 1-cycle glitch gives two pulses.
        b.sample[1] = 1'b1;
        tick(1);
        b.sample[1] = 1'b0;
        tick(2);
        chk("t6_rise", 32'(b.edge_out), 32'h2);
        tick(1);
        chk("t6_fall", 32'(b.edge_out), 32'h2);
        tick(3);
        chk("t6_cnt", 32'(b.count[15:8]), 32'h2);
`endif

        // ch2 in both-edge mode: three full toggles give six events.
        for (int k = 0; k < 6; k++) begin
            b.sample[2] = ~b.sample[2];
            tick(10);
        end
        chk("t3_cnt6", 32'(b.count[23:16]), 32'h6);
        b.mode[5:4] = 2'b00;
        b.sample[2] = 1'b1;
        tick(10);
        chk("t3_m0_lvl1", 32'(b.level[2]), 32'h1);
        b.sample[2] = 1'b0;
        tick(10);
        chk("t3_m0_lvl0", 32'(b.level[2]), 32'h0);
        chk("t3_m0_cnt", 32'(b.count[23:16]), 32'h6);
        b.cnt_clr[2] = 1'b1;
        tick(1);
        b.cnt_clr[2] = 1'b0;
        chk("t4_cntclr", 32'(b.count[23:16]), 32'h0);

        // ch3: clears issued while edge_out is high must not drop the event.
        b.sample[3] = 1'b1;
        tick(LAT + 1);
        chk("t4_flag_set", 32'(b.flag[3]), 32'h1);
        chk("t4_cnt1", 32'(b.count[31:24]), 32'h1);
        b.flag_clr[3] = 1'b1;
        tick(1);
        b.flag_clr[3] = 1'b0;
        chk("t4_flagclr", 32'(b.flag[3]), 32'h0);
        b.sample[3] = 1'b0;
        tick(LAT);
        chk("t4_edge", 32'(b.edge_out[3]), 32'h1);
        b.flag_clr[3] = 1'b1;
        b.cnt_clr[3]  = 1'b1;
        tick(1);
        b.flag_clr[3] = 1'b0;
        b.cnt_clr[3]  = 1'b0;
        chk("t4_setwins", 32'(b.flag[3]), 32'h1);
        chk("t4_clr_edge", 32'(b.count[31:24]), 32'h1);

        // The 2-bit counter instance receives five events and saturates at 3.
        for (int k = 0; k < 5; k++) begin
            bs.sample[0] = ~bs.sample[0];
            tick(LAT + 2);
        end
        chk("t4_sat", 32'(bs.count), 32'h3);
        chk("t4_sat_flag", 32'(bs.flag), 32'h1);

        // Reset arrives mid-debounce on ch0 while the input is held high.
        b.sample[0] = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_level", 32'(b.level), 32'h0);
        chk("t5_edge", 32'(b.edge_out), 32'h0);
        chk("t5_flag", 32'(b.flag), 32'h0);
        chk("t5_count", b.count, 32'h0);
        tick(LAT - 1);
        chk("t5_early", 32'(b.edge_out[0]), 32'h0);
        tick(1);
        chk("t5_edge0", 32'(b.edge_out[0]), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
